// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO pair.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
module mips_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            op_ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_div_q, is_div_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              accept, is_signed, a_neg, b_neg, last_iter;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic              div_ok;
  logic [XLEN-1:0]   div_rem_next;
  logic [2*XLEN-1:0] mul_fixed;
  logic [XLEN-1:0]   quo_fixed, rem_fixed;

  assign accept    = op_valid && (state_q == ST_IDLE);
  assign is_signed = ~op[0];
  assign a_neg     = is_signed && src_a[XLEN-1];
  assign b_neg     = is_signed && src_b[XLEN-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  // Multiply: add multiplicand into the upper half when the current LSB is set, then shift right.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  assign div_shift    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_trial    = div_shift - {1'b0, opnd_q};
  assign div_ok       = ~div_trial[XLEN];
  assign div_rem_next = div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];

  assign mul_fixed = neg_res_q ? -acc_q : acc_q;
  assign quo_fixed = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fixed = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            3'b000, 3'b001: begin
              acc_d     = {{XLEN{1'b0}}, b_mag};
              opnd_d    = a_mag;
              neg_res_d = a_neg ^ b_neg;
              is_div_d  = 1'b0;
              cnt_d     = '0;
              state_d   = ST_MUL;
            end
            3'b010, 3'b011: begin
              acc_d     = {{XLEN{1'b0}}, a_mag};
              opnd_d    = b_mag;
              a_raw_d   = src_a;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              is_div_d  = 1'b1;
              div0_d    = (src_b == '0);
              cnt_d     = '0;
              state_d   = ST_DIV;
            end
            3'b100:  hi_d = src_a;
            3'b101:  lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = ST_FIX;
      end
      ST_DIV: begin
        acc_d = {div_rem_next, acc_q[XLEN-2:0], div_ok};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = ST_FIX;
      end
      default: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = mul_fixed;
        end else if (div0_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fixed;
          lo_d = quo_fixed;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed table, corner sequences,
// and random ops checked against an arithmetic reference of HI/LO.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        op_ready, busy, done;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] mhi = 0, mlo = 0;

  mips_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .op_ready(op_ready), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference HI/LO behaviour computed with plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          mhi = a; mlo = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          q = sa / sb; r = sa % sb;
          mlo = q[31:0]; mhi = r[31:0];
        end else begin
          mlo = a / b; mhi = a % b;
        end
      end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endfunction

  task automatic wait_ready();
    int g = 0;
    while (!op_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (!op_ready) check("ready_wait", {31'b0, op_ready}, 32'd1);
  endtask

  // Issues an arithmetic op and returns during the cycle in which done is high.
  task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int cyc = 0;
    logic stable = 1'b1;
    logic [31:0] ph, pl;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    wait_ready();
    @(posedge clk); #1;
    op_valid = 1'b0;
    ph = hi; pl = lo;
    while (busy && cyc < 60) begin
      if (hi !== ph || lo !== pl || done || op_ready) stable = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    check("busy_cycles", 32'(cyc), 32'd33);
    check("hold_while_busy", {31'b0, stable}, 32'd1);
    check("done_pulse", {31'b0, done}, 32'd1);
    check("ready_at_done", {31'b0, op_ready}, 32'd1);
  endtask

  task automatic run_simple(input logic [2:0] o, input logic [31:0] a);
    op_valid = 1'b1; op = o; src_a = a; src_b = $urandom;
    wait_ready();
    @(posedge clk); #1;
    op_valid = 1'b0;
    ref_op(o, a, 32'd0);
    check("simple_busy", {31'b0, busy}, 32'd0);
    check("simple_done", {31'b0, done}, 32'd0);
    check("simple_hi", hi, mhi);
    check("simple_lo", lo, mlo);
  endtask

  initial begin
    logic seen_done;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tbl[0] = '{"mult_neg",   3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1] = '{"multu_big",  3'd1, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
    tbl[2] = '{"div_neg",    3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{"divu_100_7", 3'd3, 32'd100,       32'd7,        32'd2,         32'd14};
    tbl[4] = '{"divu_by0",   3'd3, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF};
    tbl[5] = '{"div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    tbl[6] = '{"div_by0_s",  3'd2, 32'hFFFF_FF00, 32'd0,        32'hFFFF_FF00, 32'hFFFF_FFFF};

    reset = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = 0; src_b = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ready", {31'b0, op_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_arith(tbl[i].op, tbl[i].a, tbl[i].b);
      ref_op(tbl[i].op, tbl[i].a, tbl[i].b);
      check({tbl[i].name, "_hi"}, hi, tbl[i].hi);
      check({tbl[i].name, "_lo"}, lo, tbl[i].lo);
    end

    // MTLO issued in the done cycle of a MULTU is accepted immediately.
    run_arith(3'd1, 32'hFFFF_FFFE, 32'd3);
    ref_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    run_simple(3'd5, 32'h1234);
    check("mtlo_after_done_lo", lo, 32'h1234);
    check("mtlo_after_done_hi", hi, 32'h2);

    // MTHI held during a MULT must wait for op_ready.
    run_simple(3'd4, 32'h55);
    op_valid = 1'b1; op = 3'd0; src_a = 32'd5; src_b = 32'd6;
    wait_ready();
    @(posedge clk); #1;
    op = 3'd4; src_a = 32'hAA; src_b = 32'd0;
    seen_done = 1'b0;
    for (int c = 0; c < 60 && busy; c++) begin
      if (hi !== 32'h55) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    check("mthi_blocked_hi", {31'b0, seen_done}, 32'd0);
    check("mult5x6_done", {31'b0, done}, 32'd1);
    check("mult5x6_hi", hi, 32'd0);
    check("mult5x6_lo", lo, 32'd30);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("mthi_late_hi", hi, 32'hAA);
    check("mthi_late_lo", lo, 32'd30);
    check("mthi_late_done", {31'b0, done}, 32'd0);
    mhi = 32'hAA; mlo = 32'd30;

    // Reserved op: nothing changes.
    run_simple(3'd6, 32'hDEAD_BEEF);
    check("rsvd_ready", {31'b0, op_ready}, 32'd1);

    // Reset in the middle of a DIV aborts it.
    op_valid = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
    wait_ready();
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_ready", {31'b0, op_ready}, 32'd1);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_done", {31'b0, seen_done}, 32'd0);
    mhi = 0; mlo = 0;
    run_arith(3'd1, 32'd7, 32'd8);
    ref_op(3'd1, 32'd7, 32'd8);
    check("post_abort_hi", hi, 32'd0);
    check("post_abort_lo", lo, 32'd56);

    // Random ops against the reference.
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      if (ro <= 3'd3) begin
        run_arith(ro, ra, rb);
        ref_op(ro, ra, rb);
        check("rand_hi", hi, mhi);
        check("rand_lo", lo, mlo);
      end else begin
        run_simple(ro, ra);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative multiply/divide responder that owns the HI/LO register pair for the MIPS core. The decode/execute stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests over a valid/ready handshake. The unit computes results over multiple cycles and exposes HI/LO continuously, so MFHI/MFLO read them directly. The pipeline stalls MFHI/MFLO and any new request while `busy` is high.

Parameters:
XLEN, 32, operand and HI/LO half width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  request present this cycle
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved
src_a  in  XLEN  rs operand (multiplicand / dividend / MT source)
src_b  in  XLEN  rt operand (multiplier / divisor)
op_ready  out  1  high in IDLE; request accepted on edge where op_valid && op_ready
busy  out  1  high while an arithmetic op is in flight
done  out  1  one-cycle pulse when HI/LO hold a new arithmetic result
hi  out  XLEN  current HI register
lo  out  XLEN  current LO register

Behaviour:
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, op_ready=1, counter=0. Reset wins over any request and aborts an in-flight op; partial results are discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE, op 100/101 accepted: hi (MTHI) or lo (MTLO) <= src_a on the accepting edge. No busy, no done. The next cycle stays in IDLE with op_ready=1.
- IDLE, op 110/111 accepted: no state change, no done.
- IDLE, op 000-011 accepted at edge E0:
  - Latch |src_a| and |src_b| (signed ops) or the raw values (unsigned ops).
  - Latch the result-sign flags.
  - Clear the counter; go to MUL or DIV.
  - busy=1 and op_ready=0 from the cycle after E0.
- MUL: shift-add, one multiplier bit per edge (LSB first), 2*XLEN-bit accumulator. After XLEN iterations (edges E1..E32), go to FIX.
- DIV: restoring division, one quotient bit per edge (MSB first), XLEN-bit partial remainder. After XLEN iterations (edges E1..E32), go to FIX.
- FIX (edge E33):
  - Apply sign correction and write hi/lo; go to IDLE.
  - done=1 and busy=0 during the cycle after E33; op_ready=1 in that same cycle.
  - Back-to-back issue is allowed.
- Signed multiply result: the 64-bit product is negated if the operand signs differ. Unsigned multiply: raw 64-bit product. hi = product[63:32], lo = product[31:0].
- Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign. lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU): no trap. lo = 32'hFFFFFFFF, hi = src_a as originally presented, un-negated.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- hi/lo remain stable (old values) throughout MUL/DIV/FIX until the E33 write.
- op_valid while busy is ignored; the requester must hold the request until op_ready.
- done never asserts for MT or reserved ops. done is cleared by reset.

Test Plan:
- Reset, then MULT src_a=0xFFFFFFFE, src_b=3 -> after reset hi=lo=0; busy high for 33 cycles after accept; done pulses the cycle after E33; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU src_a=0xFFFFFFFE, src_b=3 -> hi=0x00000002, lo=0xFFFFFFFA. Then MTLO src_a=0x1234 issued the cycle done is high -> accepted same cycle; lo=0x1234 next cycle; hi unchanged; no done.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIVU src_a=100, src_b=0 -> hi=0x64, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT 5*6, hold MTHI src_a=0xAA valid during busy -> MTHI is not accepted until op_ready. Final state: hi=0, lo=30 from the MULT; then the MTHI is accepted and hi=0xAA.
- Start DIV, assert reset at iteration 10 -> next cycle IDLE, hi=lo=0, busy=0, done never pulses; a subsequent MULTU 7*8 yields lo=56, hi=0.
